// File: rtl/vga_pkg.sv
// Shared constants for the frame sequencer: default 640x480@60 VGA timing,
// coordinate width and sprite slot numbering.
// Ports: none (package). Helper in_window() tests a coordinate against a span.
package vga_pkg;

  // Coordinate width for both axes; 10 bits covers the 800x525 raster.
  localparam int COORD_W = 10;

  // Default horizontal timing (pixels).
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  // Default vertical timing (lines).
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Default animation pacing.
  localparam int DEF_ANIM_DIV    = 8;
  localparam int DEF_ANIM_FRAMES = 2;

  // Sprite slots: player followed by the four ghosts.
  localparam int SPR_PLAYER = 0;
  localparam int SPR_GHOST1 = 1;
  localparam int SPR_GHOST2 = 2;
  localparam int SPR_GHOST3 = 3;
  localparam int SPR_GHOST4 = 4;
  localparam int SPR_NUM    = 5;
  localparam int SPR_IDX_W  = 3;

  // True when lo <= v < lo+len. Done in int so parameter spans never get
  // truncated to the coordinate width.
  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input int lo, input int len);
    return (int'(v) >= lo) && (int'(v) < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster timing generator: x/y counters plus registered syncs, display enable,
// vblank and frame_start, all aligned with the coordinates they describe.
// Ports: i_clk, i_rst_n (async low), i_pix_en (advance enable);
//   o_x/o_y coordinates, o_to_display, o_hsync/o_vsync (active low), o_vblank,
//   o_frame_start (1-clk pulse at 0,0), o_vblank_entry (comb: this edge enters
//   x=0,y=V_ACTIVE).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pix_en,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_to_display,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_vblank,
  output logic               o_frame_start,
  output logic               o_vblank_entry
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_ACT_LAST = COORD_W'(V_ACTIVE - 1);

  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_to_display;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_vblank;
  logic               r_frame_start;

  logic [COORD_W-1:0] w_x_nxt;
  logic [COORD_W-1:0] w_y_nxt;
  logic               w_x_wrap;
  logic               w_y_wrap;
  logic               w_frame_wrap;

  // Next-coordinate logic; equals the current value when pix_en is low.
  always_comb begin
    w_x_wrap     = (r_x == H_LAST);
    w_y_wrap     = (r_y == V_LAST);
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_frame_wrap = i_pix_en && w_x_wrap && w_y_wrap;
    if (i_pix_en) begin
      w_x_nxt = w_x_wrap ? '0 : r_x + COORD_W'(1);
      if (w_x_wrap) begin
        w_y_nxt = w_y_wrap ? '0 : r_y + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_to_display  <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_vblank      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      // Pulse only on the advancing edge that lands on 0,0, so it is never
      // stretched across idle (pix_en=0) cycles.
      r_frame_start <= w_frame_wrap;
      if (i_pix_en) begin
        r_x          <= w_x_nxt;
        r_y          <= w_y_nxt;
        // Strobes decode the next coordinates so they update on the same
        // edge as x/y and never lag them by a pixel.
        r_to_display <= in_window(w_x_nxt, 0, H_ACTIVE) &&
                        in_window(w_y_nxt, 0, V_ACTIVE);
        r_hsync      <= !in_window(w_x_nxt, H_ACTIVE + H_FP, H_SYNC);
        r_vsync      <= !in_window(w_y_nxt, V_ACTIVE + V_FP, V_SYNC);
        r_vblank     <= !in_window(w_y_nxt, 0, V_ACTIVE);
      end
    end
  end

  // Edge that moves the raster from the last active line's final pixel to
  // the start of the first blanking line.
  assign o_vblank_entry = i_pix_en && w_x_wrap && (r_y == V_ACT_LAST);

  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_to_display  = r_to_display;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_vblank      = r_vblank;
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/render_frame_sequencer.sv
// Renderer sequencer: VGA timing, animation frame index, and a double-buffered
// sprite position bank that is published to the renderer only at vblank entry.
// Ports: clk, rst_n (async low), pix_en; pos_wr_valid/idx/x/y write the
//   pending bank; commit_req/commit_ack handshake publication; x, y,
//   to_display, hsync, vsync, frame_start, vblank raster outputs; anim_frame;
//   spr_x/spr_y live bank packed {g4,g3,g2,g1,player}.
module render_frame_sequencer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int ANIM_DIV    = DEF_ANIM_DIV,
  parameter int ANIM_FRAMES = DEF_ANIM_FRAMES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pix_en,
  input  logic                       pos_wr_valid,
  input  logic [SPR_IDX_W-1:0]       pos_wr_idx,
  input  logic [COORD_W-1:0]         pos_wr_x,
  input  logic [COORD_W-1:0]         pos_wr_y,
  input  logic                       commit_req,
  output logic                       commit_ack,
  output logic [COORD_W-1:0]         x,
  output logic [COORD_W-1:0]         y,
  output logic                       to_display,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       frame_start,
  output logic                       vblank,
  output logic [1:0]                 anim_frame,
  output logic [SPR_NUM*COORD_W-1:0] spr_x,
  output logic [SPR_NUM*COORD_W-1:0] spr_y
);

  localparam int         DIV_W     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);
  localparam logic [1:0] ANIM_LAST = 2'(ANIM_FRAMES - 1);

  logic w_frame_start;
  logic w_vblank_entry;
  logic w_commit;

  logic [COORD_W-1:0] r_pend_x [SPR_NUM];
  logic [COORD_W-1:0] r_pend_y [SPR_NUM];
  logic [COORD_W-1:0] r_live_x [SPR_NUM];
  logic [COORD_W-1:0] r_live_y [SPR_NUM];
  logic [COORD_W-1:0] w_merge_x [SPR_NUM];
  logic [COORD_W-1:0] w_merge_y [SPR_NUM];

  logic               r_commit_ack;
  logic [DIV_W-1:0]   r_anim_div;
  logic [1:0]         r_anim_frame;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_pix_en       (pix_en),
    .o_x            (x),
    .o_y            (y),
    .o_to_display   (to_display),
    .o_hsync        (hsync),
    .o_vsync        (vsync),
    .o_vblank       (vblank),
    .o_frame_start  (w_frame_start),
    .o_vblank_entry (w_vblank_entry)
  );

  assign frame_start = w_frame_start;
  assign w_commit    = commit_req && w_vblank_entry;

  // Pending bank with this cycle's write folded in. Feeding the live bank
  // from the merged view lets a write landing on the commit edge be
  // published along with the rest. Indices 5-7 match no slot.
  always_comb begin
    for (int i = 0; i < SPR_NUM; i++) begin
      w_merge_x[i] = r_pend_x[i];
      w_merge_y[i] = r_pend_y[i];
      if (pos_wr_valid && (pos_wr_idx == SPR_IDX_W'(i))) begin
        w_merge_x[i] = pos_wr_x;
        w_merge_y[i] = pos_wr_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SPR_NUM; i++) begin
        r_pend_x[i] <= '0;
        r_pend_y[i] <= '0;
        r_live_x[i] <= '0;
        r_live_y[i] <= '0;
      end
      r_commit_ack <= 1'b0;
    end else begin
      for (int i = 0; i < SPR_NUM; i++) begin
        r_pend_x[i] <= w_merge_x[i];
        r_pend_y[i] <= w_merge_y[i];
        if (w_commit) begin
          r_live_x[i] <= w_merge_x[i];
          r_live_y[i] <= w_merge_y[i];
        end
      end
      r_commit_ack <= w_commit;
    end
  end

  // Animation pacing: count frame_start pulses; every ANIM_DIV-th one steps
  // the frame index, wrapping after ANIM_FRAMES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_anim_div   <= '0;
      r_anim_frame <= '0;
    end else if (w_frame_start) begin
      if (r_anim_div == DIV_LAST) begin
        r_anim_div   <= '0;
        r_anim_frame <= (r_anim_frame == ANIM_LAST) ? 2'd0 : r_anim_frame + 2'd1;
      end else begin
        r_anim_div <= r_anim_div + DIV_W'(1);
      end
    end
  end

  always_comb begin
    spr_x = '0;
    spr_y = '0;
    for (int i = 0; i < SPR_NUM; i++) begin
      spr_x[i*COORD_W +: COORD_W] = r_live_x[i];
      spr_y[i*COORD_W +: COORD_W] = r_live_y[i];
    end
  end

  assign commit_ack = r_commit_ack;
  assign anim_frame = r_anim_frame;

endmodule

// File: tb/tb_render_frame_sequencer.sv
// Directed bench for render_frame_sequencer on a shrunken 30x19 raster
// (16/4/6/4 horizontal, 12/2/2/3 vertical) so many frames fit in a short run.
// Table of raster probes, then hand sequences for frames, sparse enables,
// commits, animation and async reset.
module tb_render_frame_sequencer;

  localparam int HA = 16, HFP = 4, HS = 6, HBP = 4;
  localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;   // 30
  localparam int VT = VA + VFP + VS + VBP;   // 19
  localparam int FRAME = HT * VT;            // 570

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic        pos_wr_valid = 1'b0;
  logic [2:0]  pos_wr_idx = 3'd0;
  logic [9:0]  pos_wr_x = 10'd0;
  logic [9:0]  pos_wr_y = 10'd0;
  logic        commit_req = 1'b0;
  logic        commit_ack;
  logic [9:0]  x, y;
  logic        to_display, hsync, vsync, frame_start, vblank;
  logic [1:0]  anim_frame;
  logic [49:0] spr_x, spr_y;

  render_frame_sequencer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .ANIM_DIV(8), .ANIM_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .pos_wr_valid(pos_wr_valid), .pos_wr_idx(pos_wr_idx),
    .pos_wr_x(pos_wr_x), .pos_wr_y(pos_wr_y),
    .commit_req(commit_req), .commit_ack(commit_ack),
    .x(x), .y(y), .to_display(to_display), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .vblank(vblank), .anim_frame(anim_frame),
    .spr_x(spr_x), .spr_y(spr_y)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int pos = 0;   // model raster position (enables mod FRAME)
  int tot = 0;   // enables since last reset release

  // Background observers, sampled on the falling edge.
  int fs_cnt = 0, chg_cnt = 0, ack_cnt = 0, viol_cnt = 0;
  int fs_at [4];
  logic [1:0]  prev_anim = 2'd0;
  logic [49:0] prev_sx = '0, prev_sy = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      fs_cnt    = 0;
      chg_cnt   = 0;
      prev_anim = anim_frame;
      prev_sx   = spr_x;
      prev_sy   = spr_y;
    end else begin
      if (frame_start) fs_cnt++;
      if (anim_frame !== prev_anim) begin
        if (chg_cnt < 4) fs_at[chg_cnt] = fs_cnt;
        chg_cnt++;
      end
      prev_anim = anim_frame;
      if (commit_ack) ack_cnt++;
      if (!vblank && (spr_x !== prev_sx || spr_y !== prev_sy)) viol_cnt++;
      prev_sx = spr_x;
      prev_sy = spr_y;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit en);
    pix_en = en;
    @(posedge clk);
    #1;
    if (en) begin
      pos = (pos + 1) % FRAME;
      tot++;
    end
  endtask

  task automatic advance_to(input int target);
    int guard;
    guard = 0;
    while (pos != target && guard <= FRAME) begin
      step(1'b1);
      guard++;
    end
  endtask

  task automatic write_pos(input logic [2:0] idx, input logic [9:0] wx, input logic [9:0] wy);
    pos_wr_valid = 1'b1;
    pos_wr_idx   = idx;
    pos_wr_x     = wx;
    pos_wr_y     = wy;
    step(1'b1);
    pos_wr_valid = 1'b0;
  endtask

  typedef struct {
    int n;      // cumulative enables since reset
    int ex;
    int ey;
    bit disp;
    bit hs;
    bit vs;
    bit vb;
    bit fs;
  } vec_t;

  vec_t tbl [22];

  initial begin
    int c_fs, c_hs, c_vs, c_disp, c_vb, bad_start, trk_bad, guard;
    logic prev_hs;
    int a0;

    tbl[0]  = '{0,   0,  0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1,   1,  0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{15,  15, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{16,  16, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{19,  19, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{20,  20, 0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{25,  25, 0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{26,  26, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{29,  29, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{30,  0,  1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{345, 15, 11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{346, 16, 11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{359, 29, 11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{360, 0,  12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{419, 29, 13, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{420, 0,  14, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{440, 20, 14, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{479, 29, 15, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{480, 0,  16, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[19] = '{569, 29, 18, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[20] = '{570, 0,  0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[21] = '{571, 1,  0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset, release, idle two edges with pix_en low.
    step(1'b0);
    step(1'b0);
    rst_n = 1'b1;
    step(1'b0);
    step(1'b0);
    chk("reset_ack", commit_ack, 1'b0);
    chk("reset_anim", anim_frame, 2'd0);
    chk("reset_spr_x", spr_x, 50'd0);
    chk("reset_spr_y", spr_y, 50'd0);

    // Raster probe table.
    for (int i = 0; i < 22; i++) begin
      while (tot < tbl[i].n) step(1'b1);
      chk($sformatf("v%0d.x", i), x, tbl[i].ex);
      chk($sformatf("v%0d.y", i), y, tbl[i].ey);
      chk($sformatf("v%0d.to_display", i), to_display, tbl[i].disp);
      chk($sformatf("v%0d.hsync", i), hsync, tbl[i].hs);
      chk($sformatf("v%0d.vsync", i), vsync, tbl[i].vs);
      chk($sformatf("v%0d.vblank", i), vblank, tbl[i].vb);
      chk($sformatf("v%0d.frame_start", i), frame_start, tbl[i].fs);
    end

    // One full frame of continuous enables: strobe counts.
    c_fs = 0; c_hs = 0; c_vs = 0; c_disp = 0; c_vb = 0; bad_start = 0;
    prev_hs = hsync;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1);
      if (frame_start) c_fs++;
      if (!hsync) c_hs++;
      if (!vsync) c_vs++;
      if (to_display) c_disp++;
      if (vblank) c_vb++;
      if (!hsync && prev_hs && (pos % HT) != HA + HFP) bad_start++;
      prev_hs = hsync;
    end
    chk("frame_fs_count", c_fs, 1);
    chk("frame_hsync_low", c_hs, VT * HS);
    chk("frame_vsync_low", c_vs, VS * HT);
    chk("frame_display", c_disp, HA * VA);
    chk("frame_vblank", c_vb, (VT - VA) * HT);
    chk("hsync_start_x", bad_start, 0);

    // Sparse enables (1 in 4 clocks) over a full frame.
    c_fs = 0; trk_bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1);
      if (frame_start) c_fs++;
      if (x !== 10'(pos % HT) || y !== 10'(pos / HT)) trk_bad++;
      for (int k = 0; k < 3; k++) begin
        step(1'b0);
        if (frame_start) c_fs++;
        if (x !== 10'(pos % HT) || y !== 10'(pos / HT)) trk_bad++;
      end
    end
    chk("sparse_xy_track", trk_bad, 0);
    chk("sparse_fs_clks", c_fs, 1);

    // Player write mid-frame with commit requested: held until vblank entry.
    advance_to(90);
    commit_req = 1'b1;
    write_pos(3'd0, 10'd100, 10'd200);
    a0 = ack_cnt;
    advance_to(VA * HT - 1);
    chk("pre_commit_px", spr_x[9:0], 10'd0);
    chk("pre_commit_py", spr_y[9:0], 10'd0);
    chk("pre_commit_acks", ack_cnt - a0, 0);
    step(1'b1);
    chk("commit_px", spr_x[9:0], 10'd100);
    chk("commit_py", spr_y[9:0], 10'd200);
    chk("commit_ack_hi", commit_ack, 1'b1);
    step(1'b1);
    chk("commit_ack_lo", commit_ack, 1'b0);
    commit_req = 1'b0;

    // Frame without commit_req: ghost1 write stays pending.
    advance_to(100);
    write_pos(3'd1, 10'd11, 10'd22);
    a0 = ack_cnt;
    advance_to(VA * HT + 1);
    chk("nocommit_spr_x", spr_x, {40'd0, 10'd100});
    chk("nocommit_spr_y", spr_y, {40'd0, 10'd200});
    chk("nocommit_acks", ack_cnt - a0, 0);

    // Ignored index 6, then ghost3 written on the commit edge itself.
    commit_req = 1'b1;
    advance_to(50);
    write_pos(3'd6, 10'd777, 10'd888);
    advance_to(VA * HT - 1);
    write_pos(3'd3, 10'd5, 10'd6);
    chk("bypass_ack", commit_ack, 1'b1);
    chk("bypass_spr_x", spr_x, {10'd0, 10'd5, 10'd0, 10'd11, 10'd100});
    chk("bypass_spr_y", spr_y, {10'd0, 10'd6, 10'd0, 10'd22, 10'd200});

    // commit_req held into the next frame: exactly one more publication.
    advance_to(100);
    a0 = ack_cnt;
    write_pos(3'd4, 10'd300, 10'd400);
    advance_to(VA * HT + 1);
    chk("held_req_acks", ack_cnt - a0, 1);
    chk("held_g4_x", spr_x[49:40], 10'd300);
    chk("held_g4_y", spr_y[49:40], 10'd400);
    commit_req = 1'b0;

    // Animation: run until 24 frame_starts since reset, then stop mid-line.
    guard = 0;
    while (fs_cnt < 24 && guard < 30 * FRAME) begin
      step(1'b1);
      guard++;
    end
    chk("anim_budget", fs_cnt >= 24, 1'b1);
    advance_to(45);
    chk("anim_changes", chg_cnt, 3);
    chk("anim_step1_fs", fs_at[0], 8);
    chk("anim_step2_fs", fs_at[1], 16);
    chk("anim_step3_fs", fs_at[2], 24);
    chk("anim_now", anim_frame, 2'd1);
    chk("no_tear", viol_cnt, 0);

    // Asynchronous reset mid-line with a pending commit requested.
    commit_req = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_x", x, 10'd0);
    chk("arst_y", y, 10'd0);
    chk("arst_hsync", hsync, 1'b1);
    chk("arst_vsync", vsync, 1'b1);
    chk("arst_disp", to_display, 1'b0);
    chk("arst_vblank", vblank, 1'b0);
    chk("arst_fs", frame_start, 1'b0);
    chk("arst_ack", commit_ack, 1'b0);
    chk("arst_anim", anim_frame, 2'd0);
    chk("arst_spr_x", spr_x, 50'd0);
    chk("arst_spr_y", spr_y, 50'd0);
    step(1'b0);
    rst_n = 1'b1;
    pos = 0;
    tot = 0;
    step(1'b0);
    chk("post_rst_x", x, 10'd0);
    // Pending bank was cleared: first commit after reset publishes zeros.
    advance_to(VA * HT);
    chk("post_rst_ack", commit_ack, 1'b1);
    chk("post_rst_spr_x", spr_x, 50'd0);
    chk("post_rst_spr_y", spr_y, 50'd0);
    commit_req = 1'b0;
    step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/render_frame_sequencer.md
Name: render_frame_sequencer

Overview:
- Sequences the pixel renderer. Generates 640x480 VGA timing, the pixel coordinates, the display-enable strobe and the animation frame index.
- Double-buffers the player and four ghost positions. Game logic updates them freely; the renderer sees a coherent set that changes only during vertical blanking, so there is no sprite tearing.
- Sits between the game-state logic and the renderer and VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- ANIM_DIV, 8, frames per animation step (>=1)
- ANIM_FRAMES, 2, number of animation frames (>=2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel-rate enable; all timing state advances only when high
- pos_wr_valid  in  1  position write strobe
- pos_wr_idx  in  3  sprite select: 0 player, 1-4 ghost1-4; 5-7 ignored
- pos_wr_x  in  10  new x
- pos_wr_y  in  10  new y
- commit_req  in  1  level; request publication of the pending bank
- commit_ack  out  1  one-cycle pulse when publication happens
- x  out  10  current horizontal count
- y  out  10  current vertical count
- to_display  out  1  high when x<H_ACTIVE and y<V_ACTIVE
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- frame_start  out  1  one-cycle pulse at x=0,y=0
- vblank  out  1  high when y>=V_ACTIVE
- anim_frame  out  2  current animation frame index
- spr_x  out  50  live x positions, packed {g4,g3,g2,g1,player}
- spr_y  out  50  live y positions, same packing

Behaviour:
- Reset (async, rst_n=0): x=y=0; hsync=vsync=1; to_display=0; vblank=0; frame_start=0; commit_ack=0; anim_frame=0; both position banks=0; internal anim divider=0. All state registers release on the first clk edge after rst_n rises.
- Timing counters:
  - On clk with pix_en=1, x increments; at H_TOTAL-1 (800-1) it wraps to 0 and y increments. y wraps to 0 at V_TOTAL-1 (525-1).
  - With pix_en=0 everything holds.
- Derived outputs (to_display, hsync, vsync, vblank) are registered from the next counter values, so they are cycle-aligned with x/y. There is zero skew between coordinate and strobe.
  - hsync=0 for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync=0 for the analogous y range.
- frame_start: high for exactly one clk cycle, the cycle in which x=y=0 is first presented. It is not held over pix_en=0 cycles.
- Animation:
  - A divider counts frame_start pulses. On the ANIM_DIV-th pulse it clears, and anim_frame increments, wrapping from ANIM_FRAMES-1 to 0.
  - ANIM_DIV=1 steps every frame.
- Position writes:
  - pos_wr_valid=1 with idx 0-4 writes pos_wr_x/y into the pending bank the same edge. Idx 5-7 are dropped silently.
  - Writes are accepted every cycle, independent of pix_en.
- Commit rule:
  - Commit fires on the clk edge where commit_req=1, pix_en=1, and the counters advance into x=0,y=V_ACTIVE (the first blanking line start).
  - On that edge the live bank <= pending bank and commit_ack pulses for one cycle.
  - A pos write in the commit cycle is included in the commit (write-first bypass per index).
  - commit_req low at that point: the live bank holds, with no ack.
  - commit_req held high across frames commits once per frame.
- spr_x/spr_y always reflect the live bank and never change while vblank=0.
- Reset mid-frame restarts timing at 0,0 and clears both banks; a pending commit is lost.

Decomposition:
- Shared package (vga_pkg): the H_*/V_* timing constants, H_TOTAL/V_TOTAL, the sprite index constants (SPR_PLAYER=0, SPR_GHOST1..4=1..4, SPR_NUM=5), and coordinate widths (10 bits).
- One sub-module, vga_timing_gen: counters, syncs, to_display, vblank and frame_start.
- The top level holds the position banks, commit logic and animation divider.

Test Plan:
- Reset with pix_en=1, run 800*525 enables:
  - frame_start pulses once per 420000 enables.
  - hsync low for exactly 96 enables per line, starting at x=656.
  - vsync low on lines 490-491.
- Probe x=639,y=479: to_display=1. Probe x=640,y=479: to_display=0. Probe x=0,y=480: vblank=1.
- Pulse pix_en only every 4th clk: x advances 1 per 4 clks; frame_start is still 1 clk wide.
- Write idx0=(100,200) at y=100 with commit_req=1:
  - spr_x[9:0] stays 0 until the edge into y=480,x=0.
  - It then becomes 100 and spr_y[9:0] becomes 200, with commit_ack for 1 cycle.
- Write idx3=(5,6) on the exact commit edge: the live ghost3 slot reads (5,6) after the commit. A write to idx6 leaves all slots unchanged.
- ANIM_DIV=8, ANIM_FRAMES=2:
  - anim_frame toggles 0->1 after the 8th frame_start and 1->0 after the 16th.
  - Assert rst_n=0 mid-line: all outputs return to reset values asynchronously.
